// File: rtl/fifo16_reader_if.sv
// Downstream valid/ready stream carried out of the fifo16 reader.
// The master side presents words; the slave side accepts them.
interface fifo16_reader_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/fifo16_reader.sv
// Read-side controller for the fifo16 buffer.
// Pops words from fifo16 while there is room locally, captures each word
// the cycle after its pop, and streams the words downstream through a
// 3-entry circular queue over a valid/ready handshake.
// The queue is sized for one queued word plus one in-flight word at full
// rate, and a third slot so a stalled consumer never loses a word.
module fifo16_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_out,
    output logic                  rd_en,
    fifo16_reader_if.master       out_if,
    output logic [CNT_WIDTH-1:0]  words_out
);

    logic [1:0]            occ;
    logic                  inf;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic [DATA_WIDTH-1:0] mem [3];
    logic [DATA_WIDTH-1:0] data_q;

    logic                  transfer;
    logic                  capture;
    logic [2:0]            pending;
    logic [1:0]            occ_after_pop;
    logic [1:0]            occ_next;
    logic [1:0]            head_next;
    logic [1:0]            tail_next;
    logic [DATA_WIDTH-1:0] data_next;

    // Circular pointer advance over the three queue slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign out_if.out_valid = (occ != 2'd0);
    assign out_if.out_data  = data_q;

    // Pop request: only when fifo16 has data and queued plus in-flight
    // words leave a free slot; never depends on the consumer's ready.
    always_comb begin
        pending = {1'b0, occ} + {2'b00, inf};
        rd_en   = rst & en & ~flush & ~buf_empty & (pending < 3'd3);
    end

    // Next-state of the queue: pop on handshake, push the in-flight word,
    // and preselect the word that becomes the head after this edge.
    always_comb begin
        transfer      = out_if.out_valid & out_if.out_ready & ~flush;
        capture       = inf & ~flush;
        occ_after_pop = occ - {1'b0, transfer};
        occ_next      = occ_after_pop + {1'b0, capture};
        head_next     = transfer ? ptr_inc(head) : head;
        tail_next     = capture ? ptr_inc(tail) : tail;
        data_next     = data_q;
        if (flush) begin
            occ_next  = 2'd0;
            head_next = 2'd0;
            tail_next = 2'd0;
        end else if (occ_after_pop != 2'd0) begin
            data_next = mem[head_next];
        end else if (capture) begin
            data_next = buf_out;
        end
    end

    // Control registers, the head-word output register and the transfer counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ       <= 2'd0;
            inf       <= 1'b0;
            head      <= 2'd0;
            tail      <= 2'd0;
            data_q    <= '0;
            words_out <= '0;
        end else begin
            occ    <= occ_next;
            inf    <= rd_en;
            head   <= head_next;
            tail   <= tail_next;
            data_q <= data_next;
            if (transfer) begin
                words_out <= words_out + CNT_WIDTH'(1);
            end
        end
    end

    // Queue storage: the in-flight word lands in the tail slot.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[tail] <= buf_out;
        end
    end

endmodule
